// File: rtl/goe.sv
// goe: output engine that pairs buffered packets with their PHVs in arrival order and
// forwards each packet with the PHV metadata in its header beat, or discards it.

module goe_fifo #(
   parameter int W      = 8,
   parameter int AW     = 4,
   parameter int ALF_TH = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr,
   input  logic [W-1:0]  din,
   input  logic          rd,
   output logic [W-1:0]  dout,
   output logic          empty,
   output logic          alf
);
   localparam int DEPTH = 1 << AW;

   logic [W-1:0]  mem_r [DEPTH];
   logic [AW-1:0] wptr_r;
   logic [AW-1:0] rptr_r;
   logic [AW:0]   count_r;
   logic          full_s;
   logic          do_wr_s;
   logic          do_rd_s;

   assign full_s  = (count_r == DEPTH[AW:0]);
   assign empty   = (count_r == {(AW+1){1'b0}});
   assign alf     = (count_r >= ALF_TH[AW:0]);
   assign do_wr_s = wr && !full_s;
   assign do_rd_s = rd && !empty;
   // First-word-fall-through: the head entry is always presented on dout.
   assign dout    = mem_r[rptr_r];

   // Storage array write port.
   always_ff @(posedge clk) begin
      if (do_wr_s) begin
         mem_r[wptr_r] <= din;
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_r  <= {AW{1'b0}};
         rptr_r  <= {AW{1'b0}};
         count_r <= {(AW+1){1'b0}};
      end else begin
         if (do_wr_s) begin
            wptr_r <= wptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
         if (do_rd_s) begin
            rptr_r <= rptr_r + {{(AW-1){1'b0}}, 1'b1};
         end
         case ({do_wr_s, do_rd_s})
            2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
            2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
            default: count_r <= count_r;
         endcase
      end
   end
endmodule

module goe #(
   parameter string      PLATFORM = "Xilinx",
   parameter logic [7:0] LMID     = 8'd7,
   parameter logic [7:0] NMID     = 8'd8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [133:0]  in_goe_data,
   input  logic          in_goe_data_wr,
   input  logic          in_goe_valid_wr,
   input  logic          in_goe_valid,
   output logic          out_goe_alf,
   input  logic [1023:0] in_goe_phv,
   input  logic          in_goe_phv_wr,
   output logic          out_goe_phv_alf,
   output logic [133:0]  pktout_data,
   output logic          pktout_data_wr,
   output logic          pktout_data_valid,
   output logic          pktout_data_valid_wr,
   input  logic          in_goe_alf,
   output logic [31:0]   goe_pkt_cnt,
   output logic [31:0]   goe_drop_cnt,
   input  logic [133:0]  cin_goe_data,
   input  logic          cin_goe_data_wr,
   output logic          cout_goe_ready,
   output logic [133:0]  cout_goe_data,
   output logic          cout_goe_data_wr,
   input  logic          cin_goe_ready
);
   if ((PLATFORM != "Xilinx") && (PLATFORM != "Altera")) begin : g_bad_platform
      $error("goe: unsupported PLATFORM");
   end
   if (LMID == NMID) begin : g_bad_chain
      $error("goe: LMID and NMID must differ");
   end

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND    = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t          state_r;
   logic [127:0]    meta_r;
   logic            first_r;
   logic [133:0]    pktout_data_r;
   logic            pktout_data_wr_r;
   logic            pktout_data_valid_r;
   logic            pktout_data_valid_wr_r;
   logic [31:0]     pkt_cnt_r;
   logic [31:0]     drop_cnt_r;
   logic [133:0]    cout_data_r;
   logic            cout_data_wr_r;

   logic [133:0]    data_dout_s;
   logic            data_empty_s;
   logic            data_alf_s;
   logic            data_rd_s;
   logic            valid_dout_s;
   logic            valid_empty_s;
   logic            valid_alf_s;
   logic            valid_rd_s;
   logic [1023:0]   phv_dout_s;
   logic            phv_empty_s;
   logic            phv_rd_s;
   logic            keep_s;
   logic            tail_s;
   logic            unused_s;

   goe_fifo #(.W(134), .AW(9), .ALF_TH(400)) u_data (
      .clk(clk), .rst_n(rst_n), .wr(in_goe_data_wr), .din(in_goe_data),
      .rd(data_rd_s), .dout(data_dout_s), .empty(data_empty_s), .alf(data_alf_s)
   );

   goe_fifo #(.W(1), .AW(6), .ALF_TH(56)) u_valid (
      .clk(clk), .rst_n(rst_n), .wr(in_goe_valid_wr), .din(in_goe_valid),
      .rd(valid_rd_s), .dout(valid_dout_s), .empty(valid_empty_s), .alf(valid_alf_s)
   );

   goe_fifo #(.W(1024), .AW(5), .ALF_TH(24)) u_phv (
      .clk(clk), .rst_n(rst_n), .wr(in_goe_phv_wr), .din(in_goe_phv),
      .rd(phv_rd_s), .dout(phv_dout_s), .empty(phv_empty_s), .alf(out_goe_phv_alf)
   );

   assign out_goe_alf = data_alf_s || valid_alf_s;
   assign keep_s      = valid_dout_s && !phv_dout_s[895];
   assign tail_s      = (data_dout_s[133:132] == 2'b10);
   assign unused_s    = ^phv_dout_s[894:0];

   // FIFO pop strobes; downstream backpressure only gates packets that will be sent.
   always_comb begin
      data_rd_s  = 1'b0;
      valid_rd_s = 1'b0;
      phv_rd_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (!valid_empty_s && !phv_empty_s && (!keep_s || !in_goe_alf)) begin
               valid_rd_s = 1'b1;
               phv_rd_s   = 1'b1;
            end else begin
               valid_rd_s = 1'b0;
               phv_rd_s   = 1'b0;
            end
         end
         SEND, DISCARD: data_rd_s = !data_empty_s;
         default: data_rd_s = 1'b0;
      endcase
   end

   // Packet FSM with registered output beat and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r                <= IDLE;
         meta_r                 <= 128'd0;
         first_r                <= 1'b0;
         pktout_data_r          <= 134'd0;
         pktout_data_wr_r       <= 1'b0;
         pktout_data_valid_r    <= 1'b0;
         pktout_data_valid_wr_r <= 1'b0;
         pkt_cnt_r              <= 32'd0;
         drop_cnt_r             <= 32'd0;
      end else begin
         pktout_data_r          <= 134'd0;
         pktout_data_wr_r       <= 1'b0;
         pktout_data_valid_r    <= 1'b0;
         pktout_data_valid_wr_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (valid_rd_s) begin
                  meta_r  <= phv_dout_s[1023:896];
                  first_r <= 1'b1;
                  state_r <= keep_s ? SEND : DISCARD;
               end
            end
            SEND: begin
               if (data_rd_s) begin
                  pktout_data_r    <= first_r ? {data_dout_s[133:128], meta_r} : data_dout_s;
                  pktout_data_wr_r <= 1'b1;
                  first_r          <= 1'b0;
                  if (tail_s) begin
                     pktout_data_valid_r    <= 1'b1;
                     pktout_data_valid_wr_r <= 1'b1;
                     pkt_cnt_r              <= pkt_cnt_r + 32'd1;
                     state_r                <= IDLE;
                  end
               end
            end
            DISCARD: begin
               if (data_rd_s && tail_s) begin
                  drop_cnt_r <= drop_cnt_r + 32'd1;
                  state_r    <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   // Configuration chain pipeline stage, independent of the packet path.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cout_data_r    <= 134'd0;
         cout_data_wr_r <= 1'b0;
      end else begin
         cout_data_r    <= cin_goe_data;
         cout_data_wr_r <= cin_goe_data_wr;
      end
   end

   assign pktout_data          = pktout_data_r;
   assign pktout_data_wr       = pktout_data_wr_r;
   assign pktout_data_valid    = pktout_data_valid_r;
   assign pktout_data_valid_wr = pktout_data_valid_wr_r;
   assign goe_pkt_cnt          = pkt_cnt_r;
   assign goe_drop_cnt         = drop_cnt_r;
   assign cout_goe_data        = cout_data_r;
   assign cout_goe_data_wr     = cout_data_wr_r;
   assign cout_goe_ready       = cin_goe_ready;
endmodule

// File: tb/tb_goe.sv
// Bench for goe: packet table plus hand sequences, checked against a beat scoreboard.

module tb_goe;
   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [133:0]  in_goe_data = 134'd0;
   logic          in_goe_data_wr = 1'b0;
   logic          in_goe_valid_wr = 1'b0;
   logic          in_goe_valid = 1'b0;
   logic          out_goe_alf;
   logic [1023:0] in_goe_phv = 1024'd0;
   logic          in_goe_phv_wr = 1'b0;
   logic          out_goe_phv_alf;
   logic [133:0]  pktout_data;
   logic          pktout_data_wr;
   logic          pktout_data_valid;
   logic          pktout_data_valid_wr;
   logic          in_goe_alf = 1'b0;
   logic [31:0]   goe_pkt_cnt;
   logic [31:0]   goe_drop_cnt;
   logic [133:0]  cin_goe_data = 134'd0;
   logic          cin_goe_data_wr = 1'b0;
   logic          cout_goe_ready;
   logic [133:0]  cout_goe_data;
   logic          cout_goe_data_wr;
   logic          cin_goe_ready = 1'b0;

   goe dut (
      .clk(clk), .rst_n(rst_n),
      .in_goe_data(in_goe_data), .in_goe_data_wr(in_goe_data_wr),
      .in_goe_valid_wr(in_goe_valid_wr), .in_goe_valid(in_goe_valid),
      .out_goe_alf(out_goe_alf),
      .in_goe_phv(in_goe_phv), .in_goe_phv_wr(in_goe_phv_wr),
      .out_goe_phv_alf(out_goe_phv_alf),
      .pktout_data(pktout_data), .pktout_data_wr(pktout_data_wr),
      .pktout_data_valid(pktout_data_valid), .pktout_data_valid_wr(pktout_data_valid_wr),
      .in_goe_alf(in_goe_alf),
      .goe_pkt_cnt(goe_pkt_cnt), .goe_drop_cnt(goe_drop_cnt),
      .cin_goe_data(cin_goe_data), .cin_goe_data_wr(cin_goe_data_wr),
      .cout_goe_ready(cout_goe_ready), .cout_goe_data(cout_goe_data),
      .cout_goe_data_wr(cout_goe_data_wr), .cin_goe_ready(cin_goe_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [133:0] data;
      bit           first;
      bit           tail;
   } beat_t;

   typedef struct {
      logic [133:0] d;
      int           c;
   } cfg_t;

   typedef struct {
      int           nb;
      bit           vld;
      bit           disc;
      int           vdelay;
      bit           phvf;
      logic [127:0] meta;
      bit           exp_fwd;
   } pkt_t;

   beat_t exp_q[$];
   cfg_t  cfg_q[$];
   int    hdr_cyc[$];
   int    tail_cyc[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   int    cyc = 0;
   int    seq = 0;
   int    beats_seen = 0;
   int    exp_pkt = 0;
   int    exp_drop = 0;
   bit    quiet = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual=%h required=%h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Output monitor: pops the scoreboard on every strobed beat.
   always @(negedge clk) begin
      if (rst_n) begin
         if (quiet) chk("quiet", {133'd0, pktout_data_wr}, 134'd0);
         if (pktout_data_wr) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", pktout_data, 134'd0);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               chk("beat_data", pktout_data, e.data);
               chk("tail_strobe", {133'd0, pktout_data_valid_wr}, {133'd0, e.tail});
               if (e.first) hdr_cyc.push_back(cyc);
               if (e.tail) begin
                  tail_cyc.push_back(cyc);
                  chk("valid_bit", {133'd0, pktout_data_valid}, 134'd1);
               end
            end
         end else if (pktout_data_valid_wr) begin
            chk("stray_valid_wr", 134'd1, 134'd0);
         end
         if (cout_goe_data_wr) begin
            if (cfg_q.size() == 0) begin
               chk("cfg_unexpected", cout_goe_data, 134'd0);
            end else begin
               cfg_t c;
               c = cfg_q.pop_front();
               chk("cfg_data", cout_goe_data, c.d);
               chk("cfg_latency", 134'(cyc), 134'(c.c + 1));
            end
         end
      end
   end

   task automatic send_pkt(input int nb, input bit vld, input bit disc, input int vdelay,
                           input bit phvf, input logic [127:0] meta, input bit fwd,
                           output int tc);
      logic [1023:0] phv;
      logic [1:0]    hdr;
      logic [133:0]  beat;
      beat_t         e;
      phv = 1024'd0;
      phv[1023:896] = meta;
      phv[895] = disc;
      phv[63:0] = {$urandom, $urandom};
      seq++;
      tc = cyc;
      if (phvf) begin
         in_goe_phv = phv;
         in_goe_phv_wr = 1'b1;
         tick();
         in_goe_phv_wr = 1'b0;
      end
      for (int b = 0; b < nb; b++) begin
         hdr = (b == nb - 1) ? 2'b10 : ((b == 0) ? 2'b01 : 2'b11);
         beat = {hdr, (b == nb - 1) ? 4'd5 : 4'd0, 32'(seq), 32'(b), $urandom, $urandom};
         in_goe_data = beat;
         in_goe_data_wr = 1'b1;
         if (fwd) begin
            e.data = (b == 0) ? {beat[133:128], meta} : beat;
            e.first = (b == 0);
            e.tail = (b == nb - 1);
            exp_q.push_back(e);
         end
         if (b == nb - 1 && vdelay == 0) begin
            in_goe_valid = vld;
            in_goe_valid_wr = 1'b1;
            if (!phvf) begin
               in_goe_phv = phv;
               in_goe_phv_wr = 1'b1;
            end
            tc = cyc;
         end
         tick();
         in_goe_data_wr = 1'b0;
         in_goe_valid_wr = 1'b0;
         in_goe_phv_wr = 1'b0;
      end
      if (vdelay > 0) begin
         repeat (vdelay - 1) tick();
         in_goe_valid = vld;
         in_goe_valid_wr = 1'b1;
         if (!phvf) begin
            in_goe_phv = phv;
            in_goe_phv_wr = 1'b1;
         end
         tc = cyc;
         tick();
         in_goe_valid_wr = 1'b0;
         in_goe_phv_wr = 1'b0;
      end
      if (fwd) exp_pkt++;
      else exp_drop++;
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      if (exp_q.size() != 0) chk("drain_timeout", 134'(exp_q.size()), 134'd0);
      repeat (3) tick();
   endtask

   task automatic chk_counts(input string nm);
      chk({nm, "_pkt_cnt"}, {102'd0, goe_pkt_cnt}, 134'(exp_pkt));
      chk({nm, "_drop_cnt"}, {102'd0, goe_drop_cnt}, 134'(exp_drop));
   endtask

   task automatic chk_reset_outputs(input string nm);
      @(negedge clk);
      chk({nm, "_data_wr"}, {133'd0, pktout_data_wr}, 134'd0);
      chk({nm, "_data"}, pktout_data, 134'd0);
      chk({nm, "_valid_wr"}, {133'd0, pktout_data_valid_wr}, 134'd0);
      chk({nm, "_alf"}, {132'd0, out_goe_alf, out_goe_phv_alf}, 134'd0);
      chk({nm, "_cout_wr"}, {133'd0, cout_goe_data_wr}, 134'd0);
      chk_counts(nm);
   endtask

   pkt_t tbl[7];
   int   tc;
   int   tc2;
   int   b0;

   initial begin
      tbl[0] = '{4, 1'b1, 1'b0, 0, 1'b0, {16{8'hA5}}, 1'b1};
      tbl[1] = '{3, 1'b0, 1'b0, 0, 1'b0, {16{8'h11}}, 1'b0};
      tbl[2] = '{2, 1'b1, 1'b1, 0, 1'b0, {16{8'h22}}, 1'b0};
      tbl[3] = '{1, 1'b1, 1'b0, 0, 1'b0, {16{8'h3C}}, 1'b1};
      tbl[4] = '{5, 1'b1, 1'b0, 2, 1'b1, {16{8'h5A}}, 1'b1};
      tbl[5] = '{2, 1'b0, 1'b1, 0, 1'b1, {16{8'h66}}, 1'b0};
      tbl[6] = '{3, 1'b1, 1'b0, 1, 1'b0, {16{8'h0F}}, 1'b1};

      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      chk_reset_outputs("reset");

      // Table of single packets, each drained before the next.
      for (int i = 0; i < 7; i++) begin
         tick();
         hdr_cyc.delete();
         send_pkt(tbl[i].nb, tbl[i].vld, tbl[i].disc, tbl[i].vdelay, tbl[i].phvf,
                  tbl[i].meta, tbl[i].exp_fwd, tc);
         if (tbl[i].exp_fwd) begin
            wait_drain(60);
            if (hdr_cyc.size() == 0) chk("hdr_seen", 134'd0, 134'd1);
            else chk("hdr_latency", 134'(hdr_cyc[0] - tc), 134'd3);
         end else begin
            repeat (15) tick();
         end
         chk_counts("table");
      end

      // Discard by PHV followed immediately by a good packet: pairing order.
      send_pkt(2, 1'b1, 1'b1, 0, 1'b0, {16{8'h77}}, 1'b0, tc);
      send_pkt(3, 1'b1, 1'b0, 0, 1'b0, {16{8'h88}}, 1'b1, tc);
      wait_drain(60);
      chk_counts("order");

      // Downstream almost-full holds two queued packets, then releases them.
      in_goe_alf = 1'b1;
      hdr_cyc.delete();
      tail_cyc.delete();
      send_pkt(3, 1'b1, 1'b0, 0, 1'b0, {16{8'h91}}, 1'b1, tc);
      send_pkt(2, 1'b1, 1'b0, 0, 1'b0, {16{8'h92}}, 1'b1, tc);
      quiet = 1'b1;
      repeat (10) tick();
      quiet = 1'b0;
      in_goe_alf = 1'b0;
      wait_drain(60);
      if (hdr_cyc.size() < 2 || tail_cyc.size() < 1) chk("b2b_seen", 134'd0, 134'd1);
      else chk("b2b_gap", 134'(hdr_cyc[1] - tail_cyc[0]), 134'd2);
      chk_counts("alf_hold");

      // Almost-full thresholds: 400 data beats, 24 PHVs, no valid flags.
      for (int i = 0; i < 400; i++) begin
         in_goe_data = {2'b11, 4'd0, 128'(i)};
         in_goe_data_wr = 1'b1;
         in_goe_phv_wr = (i < 24);
         if (i == 399) begin
            @(negedge clk);
            chk("alf_at_399", {133'd0, out_goe_alf}, 134'd0);
            chk("phv_alf_at_24", {133'd0, out_goe_phv_alf}, 134'd1);
         end
         tick();
         in_goe_data_wr = 1'b0;
         in_goe_phv_wr = 1'b0;
      end
      @(negedge clk);
      chk("alf_at_400", {133'd0, out_goe_alf}, 134'd1);
      tick();
      rst_n = 1'b0;
      exp_pkt = 0;
      exp_drop = 0;
      tick();
      rst_n = 1'b1;
      chk_reset_outputs("reset2");

      // Reset while the second of six beats is on the output.
      tick();
      send_pkt(6, 1'b1, 1'b0, 0, 1'b0, {16{8'hC3}}, 1'b1, tc);
      b0 = beats_seen - 6 + exp_q.size();
      for (int i = 0; i < 40; i++) begin
         if (beats_seen >= b0 + 2) break;
         tick();
      end
      if (beats_seen < b0 + 2) chk("midsend_timeout", 134'(beats_seen - b0), 134'd2);
      rst_n = 1'b0;
      exp_q.delete();
      exp_pkt = 0;
      exp_drop = 0;
      chk_reset_outputs("reset_mid");
      tick();
      rst_n = 1'b1;
      quiet = 1'b1;
      repeat (20) tick();
      quiet = 1'b0;
      send_pkt(2, 1'b1, 1'b0, 0, 1'b0, {16{8'hE1}}, 1'b1, tc2);
      wait_drain(60);
      chk_counts("after_reset");

      // Configuration chain and ready pass-through.
      cin_goe_ready = 1'b1;
      #1 chk("ready_hi", {133'd0, cout_goe_ready}, 134'd1);
      cin_goe_ready = 1'b0;
      #1 chk("ready_lo", {133'd0, cout_goe_ready}, 134'd0);
      tick();
      for (int i = 0; i < 5; i++) begin
         cfg_t c;
         c.d = {6'(i), $urandom, $urandom, $urandom, $urandom};
         c.c = cyc;
         cin_goe_data = c.d;
         cin_goe_data_wr = 1'b1;
         cfg_q.push_back(c);
         tick();
      end
      cin_goe_data_wr = 1'b0;
      repeat (3) tick();
      chk("cfg_left", 134'(cfg_q.size()), 134'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
